// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline flow controller.
// Optional stall performance counter is enabled by the PIPE_STALL_PERF_EN macro.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE       = 1'b0,
    ERET_FLUSH = 1'b1
  } flow_state_e;

  localparam int unsigned MULT_CYC_DEFAULT = 5;
  localparam int unsigned DIV_CYC_DEFAULT  = 10;
  localparam int unsigned CNT_W_DEFAULT    = 4;

  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads on an idle start unless the starting
// instruction is killed, otherwise counts down to zero and holds there.
module md_busy_counter #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic             kill,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load && !kill && (cnt_q == '0)) begin
      cnt_d = is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

  // A live start while busy means the decode stall logic let one through.
  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (reset) !(load && !kill && busy)
  );

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Central flow controller: per-stage write enables, bubbles/flushes, exception
// broadcast and ERET sequencing. Macro PIPE_STALL_PERF_EN adds stall_cnt.
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEFAULT,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_hazard,
  input  logic             d_is_md,
  input  logic             d_is_eret,
  input  logic             e_md_start,
  input  logic             e_md_is_div,
  input  logic             int_req,
  output logic             f_we,
  output logic             d_we,
  output logic             e_we,
  output logic             m_we,
  output logic             e_flush,
  output logic             d_flush,
  output logic             req,
  output logic             eret_pc_sel,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  flow_state_e state_q;
  flow_state_e state_d;
  logic        stall;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (e_md_start),
    .is_div (e_md_is_div),
    .kill   (int_req),
    .cnt    (md_cnt),
    .busy   (md_busy)
  );

  assign stall = d_hazard | (d_is_md & (md_busy | e_md_start));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A second eret seen during ERET_FLUSH is already squashed, so it is ignored.
  always_comb begin
    state_d = state_q;
    if (int_req) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:       if (d_is_eret && !stall) state_d = ERET_FLUSH;
        ERET_FLUSH: state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    f_we        = 1'b1;
    d_we        = 1'b1;
    e_we        = 1'b1;
    m_we        = 1'b1;
    e_flush     = 1'b0;
    d_flush     = 1'b0;
    req         = 1'b0;
    eret_pc_sel = 1'b0;
    if (int_req) begin
      req = 1'b1;
    end else if (state_q == ERET_FLUSH) begin
      d_flush     = 1'b1;
      eret_pc_sel = 1'b1;
    end else if (stall) begin
      f_we    = 1'b0;
      d_we    = 1'b0;
      e_flush = 1'b1;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !int_req) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: vector table plus scoreboarded
// multi-cycle sequences (md counter, eret, interrupts, reset mid-operation).
module tb_pipe_flow_ctrl;

  localparam int unsigned CNT_W = 4;

  // Control group order: f_we d_we e_we m_we e_flush d_flush req eret_pc_sel
  localparam logic [7:0] C_NORM  = 8'b1111_0000;
  localparam logic [7:0] C_STALL = 8'b0011_1000;
  localparam logic [7:0] C_REQ   = 8'b1111_0010;
  localparam logic [7:0] C_ERET  = 8'b1111_0101;

  // Input order: d_hazard d_is_md d_is_eret e_md_start e_md_is_div int_req
  typedef struct {
    logic [5:0]       in;
    logic [7:0]       ctl;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    string            name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic d_hazard, d_is_md, d_is_eret, e_md_start, e_md_is_div, int_req;
  logic f_we, d_we, e_we, m_we, e_flush, d_flush, req, eret_pc_sel, md_busy;
  logic [CNT_W-1:0] md_cnt;
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        sb_q[$];
  vec_t        tbl[11];

  always #5 clk = ~clk;

  pipe_flow_ctrl #(
    .MULT_CYC (5),
    .DIV_CYC  (10),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_hazard    (d_hazard),
    .d_is_md     (d_is_md),
    .d_is_eret   (d_is_eret),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .int_req     (int_req),
    .f_we        (f_we),
    .d_we        (d_we),
    .e_we        (e_we),
    .m_we        (m_we),
    .e_flush     (e_flush),
    .d_flush     (d_flush),
    .req         (req),
    .eret_pc_sel (eret_pc_sel),
    .md_busy     (md_busy),
    .md_cnt      (md_cnt)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic drive(input logic [5:0] in);
    {d_hazard, d_is_md, d_is_eret, e_md_start, e_md_is_div, int_req} = in;
  endtask

  // Drive one cycle of inputs, queue the expectation, compare mid-cycle.
  task automatic step(input logic [5:0] in, input logic [7:0] ctl,
                      input logic busy, input logic [CNT_W-1:0] cnt,
                      input string name);
    vec_t e;
    vec_t x;
    logic [7:0] act_ctl;
    e.in = in; e.ctl = ctl; e.busy = busy; e.cnt = cnt; e.name = name;
    drive(in);
    sb_q.push_back(e);
    @(negedge clk);
    x = sb_q.pop_front();
    act_ctl = {f_we, d_we, e_we, m_we, e_flush, d_flush, req, eret_pc_sel};
    n_checks++;
    if (act_ctl !== x.ctl || md_busy !== x.busy || md_cnt !== x.cnt) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b busy=%b cnt=%0d, expected ctl=%b busy=%b cnt=%0d",
               x.name, act_ctl, md_busy, md_cnt, x.ctl, x.busy, x.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(6'b000000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

`ifdef PIPE_STALL_PERF_EN
  task automatic check_stall_cnt(input logic [31:0] exp, input string name);
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== exp) begin
      n_fail++;
      $display("FAIL %s: got stall_cnt=%0d, expected %0d", name, stall_cnt, exp);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // All table rows start and end in IDLE with the md counter empty.
    tbl[0]  = '{6'b000000, C_NORM,  1'b0, 4'd0, "tbl_idle"};
    tbl[1]  = '{6'b100000, C_STALL, 1'b0, 4'd0, "tbl_hazard"};
    tbl[2]  = '{6'b010000, C_NORM,  1'b0, 4'd0, "tbl_md_no_conflict"};
    tbl[3]  = '{6'b101000, C_STALL, 1'b0, 4'd0, "tbl_eret_stalled"};
    tbl[4]  = '{6'b000001, C_REQ,   1'b0, 4'd0, "tbl_int"};
    tbl[5]  = '{6'b100001, C_REQ,   1'b0, 4'd0, "tbl_int_over_hazard"};
    tbl[6]  = '{6'b010101, C_REQ,   1'b0, 4'd0, "tbl_int_over_md_stall"};
    tbl[7]  = '{6'b000111, C_REQ,   1'b0, 4'd0, "tbl_int_kills_div"};
    tbl[8]  = '{6'b111111, C_REQ,   1'b0, 4'd0, "tbl_all_high"};
    tbl[9]  = '{6'b001001, C_REQ,   1'b0, 4'd0, "tbl_int_over_eret"};
    tbl[10] = '{6'b000000, C_NORM,  1'b0, 4'd0, "tbl_settle"};

    reset = 1'b1;
    drive(6'b000000);
    @(posedge clk);
    #1;
    do_reset();
    step(6'b000000, C_NORM, 1'b0, 4'd0, "reset_state");

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].in, tbl[i].ctl, tbl[i].busy, tbl[i].cnt, tbl[i].name);
    end
`ifdef PIPE_STALL_PERF_EN
    check_stall_cnt(32'd2, "perf_after_table");
`endif

    // mult issue with a dependent HI/LO reader held in D
    step(6'b010100, C_STALL, 1'b0, 4'd0, "mult_issue");
    for (int k = 5; k >= 1; k--) begin
      step(6'b010000, C_STALL, 1'b1, CNT_W'(k), "mult_busy");
    end
    step(6'b010000, C_NORM, 1'b0, 4'd0, "mult_resume");

    // div start killed by interrupt
    step(6'b000111, C_REQ,  1'b0, 4'd0, "div_int_req");
    step(6'b000000, C_NORM, 1'b0, 4'd0, "div_int_no_load");

    // eret, with a back-to-back eret squashed during ERET_FLUSH
    step(6'b001000, C_NORM, 1'b0, 4'd0, "eret_issue");
    step(6'b001000, C_ERET, 1'b0, 4'd0, "eret_flush");
    step(6'b000000, C_NORM, 1'b0, 4'd0, "eret_back_idle");

    // interrupt during ERET_FLUSH
    step(6'b001000, C_NORM, 1'b0, 4'd0, "eret2_issue");
    step(6'b000001, C_REQ,  1'b0, 4'd0, "eret_int_req");
    step(6'b000000, C_NORM, 1'b0, 4'd0, "eret_int_idle");

    // counter keeps running through an interrupt, then reset mid-operation
    step(6'b000110, C_NORM, 1'b0, 4'd0,  "div_issue");
    step(6'b000001, C_REQ,  1'b1, 4'd10, "div_busy_int");
    step(6'b000000, C_NORM, 1'b1, 4'd9,  "div_keeps_counting");
    step(6'b001000, C_NORM, 1'b1, 4'd8,  "eret_before_reset");
    do_reset();
    step(6'b000000, C_NORM, 1'b0, 4'd0, "reset_mid_op");

    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(6'b100000, C_STALL, 1'b0, 4'd0, "hazard_stall");
    end
    step(6'b000000, C_NORM, 1'b0, 4'd0, "hazard_release");
`ifdef PIPE_STALL_PERF_EN
    check_stall_cnt(32'd3, "perf_hazard");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Central flow controller for the five-stage MIPS pipeline registers (F/D, D/E, E/M, M/W).
- Generates every per-stage write-enable (WE) and bubble/flush, plus the broadcast exception request `req` that pipeline registers use to clear and load PC 0x4180.
- Owns the multiply/divide busy counter and a small ERET sequencing FSM.
- Sits beside the datapath; all hazard and exception inputs come from decode/CP0 logic.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu.
- DIV_CYC, 10, busy cycles for div/divu.
- CNT_W, 4, md counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- d_hazard  in  1  Tuse/Tnew data hazard for the D-stage instruction (combinational, external)
- d_is_md  in  1  D instr reads/writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- d_is_eret  in  1  D instr is eret
- e_md_start  in  1  E instr is mult/multu/div/divu
- e_md_is_div  in  1  qualifies e_md_start: 1 = div class
- int_req  in  1  CP0 exception/interrupt taken at M
- f_we, d_we, e_we, m_we  out  1 each  pipeline register write enables
- e_flush  out  1  insert bubble into D/E register
- d_flush  out  1  squash F/D register contents
- req  out  1  exception flush broadcast to all pipeline registers
- eret_pc_sel  out  1  NPC selects EPC
- md_busy  out  1  counter nonzero
- md_cnt  out  CNT_W  remaining busy cycles

Behaviour:
Reset:
- md_cnt = 0, md_busy = 0, FSM = IDLE.
- Combinational outputs therefore reset to: f_we = d_we = e_we = m_we = 1; e_flush = d_flush = req = eret_pc_sel = 0.

Stall:
- stall = d_hazard | (d_is_md & (md_busy | e_md_start)).

Output priority, highest first:
1. int_req = 1:
   - req = 1; all WE = 1; d_flush = e_flush = 0 (req already clears every register); eret_pc_sel = 0.
   - FSM -> IDLE next edge.
   - e_md_start is ignored (the killed instruction must not load the counter).
   - A counter already running keeps decrementing.
2. FSM = ERET_FLUSH:
   - d_flush = 1 (kills the wrong-path instruction fetched after eret); eret_pc_sel = 1; all WE = 1.
   - -> IDLE.
3. stall = 1:
   - f_we = d_we = 0; e_flush = 1, e_we = 1 (bubble into E); m_we = 1.
4. Otherwise: all WE = 1, flushes = 0.

FSM transitions:
- IDLE -> ERET_FLUSH when d_is_eret & !stall & !int_req (eret advances this edge).
- ERET_FLUSH is always exactly one cycle.
- Back-to-back eret: a second eret arriving in D during ERET_FLUSH is squashed by d_flush, so it is not recognised.

MD counter:
- Loads on e_md_start & !int_req & (md_cnt == 0):
  - e_md_is_div ? DIV_CYC : MULT_CYC.
- Else decrements when nonzero; saturates at 0.
- md_busy = (md_cnt != 0).
- e_md_start while busy cannot happen: the stall rule prevents it. It is ignored, and an assertion fires under simulation.

Reset mid-operation:
- Counter clears and FSM returns to IDLE on the same edge.

Optional Feature:
- Macro PIPE_STALL_PERF_EN.
- When defined:
  - Extra output stall_cnt [31:0] counts cycles with stall = 1 and int_req = 0.
  - Wraps at 2^32; cleared by reset.
- When undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - FSM state enum {IDLE, ERET_FLUSH}.
  - Default MULT_CYC/DIV_CYC constants.
  - PC constant EXC_ENTRY = 32'h0000_4180.
- One sub-module md_busy_counter:
  - Inputs: load, is_div, kill.
  - Outputs: cnt, busy.

Test Plan:
1. Reset held 2 cycles, then released -> all WE = 1, md_cnt = 0, req = 0, eret_pc_sel = 0.
2. e_md_start = 1, e_md_is_div = 0, then d_is_md = 1 held -> md_cnt = 5, 4, 3, 2, 1, 0; f_we = 0 and e_flush = 1 for 6 cycles (includes the issue cycle), resumes on the 7th.
3. Div start coincident with int_req = 1 -> md_cnt stays 0, req = 1, no stall.
4. d_is_eret = 1, no hazard -> next cycle d_flush = 1 and eret_pc_sel = 1 for exactly one cycle, then IDLE.
5. FSM in ERET_FLUSH and int_req = 1 -> req = 1, d_flush = 0, FSM = IDLE next cycle.
6. d_hazard = 1 for 3 cycles with md idle -> f_we = d_we = 0 and e_flush = 1 for exactly 3 cycles.
   - With PIPE_STALL_PERF_EN, stall_cnt = 3.
